// File: rtl/struct_rec_fifo_pkg.sv
// Record and statistics types shared by the struct_rec_fifo block and its storage.
// rec_t packs {a, b, c, x, y} with a at the MSB and y at bit 0.
package struct_rec_fifo_pkg;

    localparam int REC_BITS = 8;

    typedef struct packed {
        logic                a;
        logic [REC_BITS-1:0] b;
        byte                 c;
        logic                x;
        logic                y;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    typedef struct packed signed {
        logic signed [15:0] net;
        logic [7:0]         pushes;
        logic [7:0]         drops;
    } stats_t;

endpackage

// File: rtl/struct_rec_mem.sv
// DEPTH x rec_t register array, one synchronous write port and one asynchronous read port.
// Contents are deliberately left unreset; occupancy tracking lives in the FIFO control.
module struct_rec_mem
    import struct_rec_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  rec_t          wr_dat,
    input  logic [AW-1:0] rd_addr,
    output rec_t          rd_dat
);

    rec_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/struct_rec_fifo.sv
// Record FIFO: packs input fields into rec_t on write, shows packed word and field b on read.
// Latency 1 cycle (FWFT=1) or 2 cycles (FWFT=0); in_ready = !full, a pop never frees a same-cycle push.
// Optional counters under STRUCT_REC_FIFO_STATS_EN; otherwise stats reads zero.
module struct_rec_fifo
    import struct_rec_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FWFT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_a,
    input  logic [REC_BITS-1:0]        in_b,
    input  logic [7:0]                 in_c,
    input  logic                       in_x,
    input  logic                       in_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REC_W-1:0]           out_rec,
    output logic [REC_BITS-1:0]        out_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                stats
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, rd_adv;
    rec_t          wr_rec, mem_rd, head;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign count    = count_q;
    assign out_rec  = head;
    assign out_b    = head.b;
    assign wr_rec   = '{a: in_a, b: in_b, c: in_c, x: in_x, y: in_y};

    always_comb begin
        wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    struct_rec_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_dat  (wr_rec),
        .rd_addr (rd_ptr_q),
        .rd_dat  (mem_rd)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign out_valid = (count_q != '0);
            assign rd_adv    = pop;
            // Gate the raw storage so an empty FIFO presents zeros, not stale records.
            assign head      = out_valid ? mem_rd : rec_t'('0);
        end else begin : g_reg
            rec_t          stage_q;
            logic          stage_vld_q;
            logic [CW-1:0] mem_cnt;
            logic          load;

            // count covers the staged record too, so storage holds count minus the stage.
            assign mem_cnt   = count_q - CW'(stage_vld_q);
            assign load      = (mem_cnt != '0) && (!stage_vld_q || out_ready);
            assign out_valid = stage_vld_q;
            assign rd_adv    = load;
            assign head      = stage_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q     <= '0;
                    stage_vld_q <= 1'b0;
                end else if (load) begin
                    stage_q     <= mem_rd;
                    stage_vld_q <= 1'b1;
                end else if (pop) begin
                    stage_vld_q <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef STRUCT_REC_FIFO_STATS_EN
    stats_t stats_q, stats_d;

    always_comb begin
        stats_d = stats_q;
        if (push && !pop) begin
            stats_d.net = stats_q.net + 16'sd1;
        end else if (pop && !push) begin
            stats_d.net = stats_q.net - 16'sd1;
        end
        if (push) begin
            stats_d.pushes = stats_q.pushes + 8'd1;
        end
        if (in_valid && !in_ready && (stats_q.drops != 8'hFF)) begin
            stats_d.drops = stats_q.drops + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign stats = stats_q;
`else
    assign stats = 32'h0;
`endif

endmodule

// File: tb/tb_struct_rec_fifo.sv
// Randomised and directed checks of struct_rec_fifo (FWFT=1 and FWFT=0 instances) against queue models.
module tb_struct_rec_fifo;
    import struct_rec_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          in_a = 1'b0, in_x = 1'b0, in_y = 1'b0;
    logic [7:0]    in_b = 8'h0, in_c = 8'h0;

    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [REC_W-1:0] out_rec;
    logic [7:0]    out_b;
    logic [CW-1:0] count;
    logic [31:0]   stats;

    logic          in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic          in_ready0, out_valid0;
    logic [REC_W-1:0] out_rec0;
    logic [7:0]    out_b0;
    logic [CW-1:0] count0;
    logic [31:0]   stats0;

    logic [18:0] q1[$];
    logic [18:0] q0[$];
    int          e0[$];
    int          edge_n = 0;
    int          s_net = 0, s_push = 0, s_drop = 0;
    int          vectors = 0, errs = 0;

    always #5 clk = ~clk;

    struct_rec_fifo #(.DEPTH(DEPTH), .FWFT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
        .out_b(out_b), .count(count), .stats(stats)
    );

    struct_rec_fifo #(.DEPTH(DEPTH), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_rec(out_rec0),
        .out_b(out_b0), .count(count0), .stats(stats0)
    );

    function automatic logic [18:0] pk(input logic a, input logic [7:0] b,
                                       input logic [7:0] c, input logic x, input logic y);
        return {a, b, c, x, y};
    endfunction

    function automatic logic [31:0] exp_stats();
`ifdef STRUCT_REC_FIFO_STATS_EN
        logic [15:0] n;
        n = 16'(s_net);
        return {n, 8'(s_push), 8'(s_drop)};
`else
        return 32'h0;
`endif
    endfunction

    task automatic rand_fields();
        in_a = 1'($urandom);
        in_b = 8'($urandom);
        in_c = 8'($urandom);
        in_x = 1'($urandom);
        in_y = 1'($urandom);
    endtask

    // Advance one clock and apply the FIFO rules to the reference queues.
    // FWFT=0 head is visible only once it was pushed on an earlier edge than the current one.
    task automatic clk_model();
        bit p1, po1, d1, p0, po0;
        logic [18:0] r;
        r   = pk(in_a, in_b, in_c, in_x, in_y);
        p1  = in_valid && (q1.size() < DEPTH);
        po1 = out_ready && (q1.size() != 0);
        d1  = in_valid && (q1.size() == DEPTH);
        p0  = in_valid0 && (q0.size() < DEPTH);
        po0 = (q0.size() != 0) ? (out_ready0 && (e0[0] < edge_n)) : 1'b0;
        @(posedge clk);
        edge_n++;
        vectors++;
        if (po1) void'(q1.pop_front());
        if (p1) q1.push_back(r);
        if (po0) begin
            void'(q0.pop_front());
            void'(e0.pop_front());
        end
        if (p0) begin
            q0.push_back(r);
            e0.push_back(edge_n);
        end
        s_net  = s_net + int'(p1) - int'(po1);
        s_push = (s_push + int'(p1)) % 256;
        if (d1 && s_drop < 255) s_drop++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        q1.delete(); q0.delete(); e0.delete();
        s_net = 0; s_push = 0; s_drop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        if (count !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_ctl: count=%0d in_ready=%b out_valid=%b want 0/1/0", count, in_ready, out_valid);
        end
        if (out_rec !== '0 || out_b !== 8'h0 || stats !== 32'h0) begin
            errs++; $display("FAIL reset_dat: out_rec=%h out_b=%h stats=%h want 0", out_rec, out_b, stats);
        end
        if (count0 !== '0 || in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || out_rec0 !== '0 || stats0 !== 32'h0) begin
            errs++; $display("FAIL reset_fwft0: count=%0d rdy=%b vld=%b rec=%h stats=%h", count0, in_ready0, out_valid0, out_rec0, stats0);
        end
        do_reset();
    endtask

    task automatic test_single_push();
        logic [18:0] want;
        do_reset();
        in_a = 1'b1; in_b = 8'hFF; in_c = 8'hAA; in_x = 1'b1; in_y = 1'b0;
        want = pk(1'b1, 8'hFF, 8'hAA, 1'b1, 1'b0);
        in_valid = 1'b1;
        clk_model();
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || count !== CW'(1)) begin
            errs++; $display("FAIL single_ctl: out_valid=%b count=%0d want 1/1", out_valid, count);
        end
        if (out_rec !== want || out_rec !== q1[0]) begin
            errs++; $display("FAIL single_rec: out_rec=%h want %h", out_rec, want);
        end
        if (out_b !== 8'hFF || out_rec[9:2] !== 8'hAA) begin
            errs++; $display("FAIL single_fields: out_b=%h c=%h want ff/aa", out_b, out_rec[9:2]);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] cs [4];
        cs[0] = 8'h11; cs[1] = 8'h22; cs[2] = 8'h33; cs[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            in_c = cs[i];
            in_valid = 1'b1;
            clk_model();
        end
        in_valid = 1'b0;
        if (count !== CW'(4) || in_ready !== 1'b0) begin
            errs++; $display("FAIL full: count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || out_rec[9:2] !== cs[i] || out_rec !== q1[0]) begin
                errs++; $display("FAIL drain_%0d: vld=%b c=%h want c=%h", i, out_valid, out_rec[9:2], cs[i]);
            end
            clk_model();
            if (i == 0 && in_ready !== 1'b1) begin
                errs++; $display("FAIL drain_ready: in_ready=%b want 1", in_ready);
            end
        end
        out_ready = 1'b0;
        if (count !== '0 || out_valid !== 1'b0) begin
            errs++; $display("FAIL drained: count=%0d out_valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            in_b = 8'(i);
            clk_model();
            if (count !== CW'(1) || out_valid !== 1'b1 || out_b !== 8'(i) || out_b !== q1[0][17:10]) begin
                errs++; $display("FAIL b2b_%0d: count=%0d vld=%b out_b=%h want 1/1/%h", i, count, out_valid, out_b, 8'(i));
            end
        end
        in_valid = 1'b0;
        clk_model();
        out_ready = 1'b0;
        if (count !== '0) begin
            errs++; $display("FAIL b2b_end: count=%0d want 0", count);
        end
    endtask

    task automatic test_fwft0();
        do_reset();
        rand_fields();
        in_b = 8'h55;
        in_valid0 = 1'b1;
        clk_model();
        in_valid0 = 1'b0;
        if (out_valid0 !== 1'b0 || count0 !== CW'(1)) begin
            errs++; $display("FAIL fwft0_early: out_valid=%b count=%0d want 0/1", out_valid0, count0);
        end
        clk_model();
        if (out_valid0 !== 1'b1 || out_b0 !== 8'h55 || out_rec0 !== q0[0]) begin
            errs++; $display("FAIL fwft0_late: out_valid=%b out_b=%h want 1/55", out_valid0, out_b0);
        end
        out_ready0 = 1'b1;
        clk_model();
        out_ready0 = 1'b0;
        if (out_valid0 !== 1'b0 || count0 !== '0) begin
            errs++; $display("FAIL fwft0_pop: out_valid=%b count=%0d want 0/0", out_valid0, count0);
        end
    endtask

    task automatic test_random();
        bit vis0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (count !== CW'(q1.size()) || in_ready !== (q1.size() < DEPTH) || out_valid !== (q1.size() != 0)) begin
                errs++; $display("FAIL rnd_ctl1 @%0d: count=%0d rdy=%b vld=%b want count=%0d", i, count, in_ready, out_valid, q1.size());
            end
            if (q1.size() != 0 && (out_rec !== q1[0] || out_b !== q1[0][17:10])) begin
                errs++; $display("FAIL rnd_dat1 @%0d: out_rec=%h out_b=%h want %h", i, out_rec, out_b, q1[0]);
            end
            vis0 = (q0.size() != 0) ? (e0[0] < edge_n) : 1'b0;
            if (count0 !== CW'(q0.size()) || in_ready0 !== (q0.size() < DEPTH) || out_valid0 !== vis0) begin
                errs++; $display("FAIL rnd_ctl0 @%0d: count=%0d rdy=%b vld=%b want count=%0d vld=%b", i, count0, in_ready0, out_valid0, q0.size(), vis0);
            end
            if (vis0 && (out_rec0 !== q0[0] || out_b0 !== q0[0][17:10])) begin
                errs++; $display("FAIL rnd_dat0 @%0d: out_rec=%h want %h", i, out_rec0, q0[0]);
            end
            rand_fields();
            if (i < 300) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                out_ready  = ($urandom_range(0, 2) == 0);
                in_valid0  = ($urandom_range(0, 3) != 0);
                out_ready0 = ($urandom_range(0, 2) == 0);
            end else begin
                in_valid   = ($urandom_range(0, 2) == 0);
                out_ready  = ($urandom_range(0, 3) != 0);
                in_valid0  = ($urandom_range(0, 2) == 0);
                out_ready0 = ($urandom_range(0, 3) != 0);
            end
            clk_model();
        end
        in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            clk_model();
        end
        in_valid = 1'b0;
        if (count !== CW'(3)) begin
            errs++; $display("FAIL arst_pre: count=%0d want 3", count);
        end
        #3;
        rst = 1'b1;
        #1;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_rec !== '0) begin
            errs++; $display("FAIL arst_now: count=%0d vld=%b rdy=%b rec=%h want 0/0/1/0", count, out_valid, in_ready, out_rec);
        end
        q1.delete(); q0.delete(); e0.delete();
        s_net = 0; s_push = 0; s_drop = 0;
        #1;
        rst = 1'b0;
        rand_fields();
        in_valid = 1'b1;
        clk_model();
        in_valid = 1'b0;
        if (count !== CW'(1) || out_valid !== 1'b1 || out_rec !== q1[0] || out_b !== q1[0][17:10]) begin
            errs++; $display("FAIL arst_post: count=%0d vld=%b rec=%h want 1/1/%h", count, out_valid, out_rec, q1[0]);
        end
    endtask

    task automatic test_stats();
        logic [31:0] want;
`ifdef STRUCT_REC_FIFO_STATS_EN
        want = 32'h0003_0503;
`else
        want = 32'h0;
`endif
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rand_fields();
            clk_model();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) clk_model();
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_fields();
        clk_model();
        in_valid = 1'b0;
        if (stats !== want || stats !== exp_stats()) begin
            errs++; $display("FAIL stats: got %h want %h (model %h)", stats, want, exp_stats());
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_fwft0();
        test_random();
        test_async_reset();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
